fb_scanout: RTL and testbench

// Video scanout engine: the reader on the framebuffer read port (fb_read_x/y/en -> fb_read_data/valid).

---
 rtl/celery_pkg.sv | 38 +++
 rtl/video_timing_gen.sv | 61 ++++++
 rtl/fb_scanout.sv | 147 ++++++++++++++
 tb/tb_fb_scanout.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/celery_pkg.sv
// Shared pixel types for the rasterizer / scanout slice.
//   rgb565_t       : framebuffer pixel format
//   rgb888_t       : video encoder pixel format, {r,g,b}
//   pix_tag_t      : per-pixel raster flags carried down the scanout delay line
//   rgb565_to_888(): bit-replicating colour expansion
package celery_pkg;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // hsync/vsync are stored as "sync window active" (polarity applied at the output)
    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
        logic first;
        logic issued;
    } pix_tag_t;

    // Replicating the top bits makes full-scale 565 map to full-scale 888
    function automatic rgb888_t rgb565_to_888(input rgb565_t c);
        rgb888_t o;
        o.r = {c.r, c.r[4:2]};
        o.g = {c.g, c.g[5:4]};
        o.b = {c.b, c.b[4:2]};
        return o;
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing counters for the scanout engine.
// Per axis the raw order is: active, front porch, sync, back porch.
// Ports:
//   clk, rst     : pixel clock, synchronous active-high reset
//   h_cnt, v_cnt : current raster position (0..TOTAL-1)
//   active       : position lies in the active area
//   hsync, vsync : position lies in the sync window (active-high, raw)
//   first_pixel  : position is (0,0)
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int unsigned VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          first_pixel
);
    import celery_pkg::*;

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEGIN = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_BEGIN + H_SYNC;
    localparam int unsigned VS_BEGIN = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_BEGIN + V_SYNC;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (32'(h_cnt) == H_TOTAL - 1) begin
            h_cnt <= '0;
            if (32'(v_cnt) == V_TOTAL - 1)
                v_cnt <= '0;
            else
                v_cnt <= v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        active      = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
        hsync       = (32'(h_cnt) >= HS_BEGIN) && (32'(h_cnt) < HS_END);
        vsync       = (32'(v_cnt) >= VS_BEGIN) && (32'(v_cnt) < VS_END);
        first_pixel = (h_cnt == '0) && (v_cnt == '0);
    end

endmodule

// File: rtl/fb_scanout.sv
// Video scanout engine: walks the raster, fetches one RGB565 pixel per clock
// from the framebuffer read port and drives RGB888 + syncs to the encoder.
// Ports:
//   clk, rst                  : pixel clock, synchronous active-high reset
//   enable                    : 0 = timing keeps running, no reads, de/rgb forced 0
//   border_color              : shown for active pixels outside the FB and on underflow
//   fb_read_x/y/en            : registered read request, one pixel per cycle
//   fb_read_data/valid        : read return, READ_LATENCY cycles after fb_read_en
//   vid_rgb/hsync/vsync/de    : registered video outputs
//   frame_start               : pulse with output pixel (0,0)
//   underflow                 : pulse with a pixel whose read returned no data
module fb_scanout #(
    parameter int unsigned H_ACTIVE         = 640,
    parameter int unsigned H_FP             = 16,
    parameter int unsigned H_SYNC           = 96,
    parameter int unsigned H_BP             = 48,
    parameter int unsigned V_ACTIVE         = 480,
    parameter int unsigned V_FP             = 10,
    parameter int unsigned V_SYNC           = 2,
    parameter int unsigned V_BP             = 33,
    parameter int unsigned SYNC_ACTIVE_HIGH = 0,
    parameter int unsigned FB_WIDTH         = 640,
    parameter int unsigned FB_HEIGHT        = 480,
    parameter int unsigned READ_LATENCY     = 1,
    localparam int unsigned XW = (FB_WIDTH  > 1) ? $clog2(FB_WIDTH)  : 1,
    localparam int unsigned YW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  celery_pkg::rgb565_t border_color,
    output logic [XW-1:0]       fb_read_x,
    output logic [YW-1:0]       fb_read_y,
    output logic                fb_read_en,
    input  celery_pkg::rgb565_t fb_read_data,
    input  logic                fb_read_valid,
    output celery_pkg::rgb888_t vid_rgb,
    output logic                vid_hsync,
    output logic                vid_vsync,
    output logic                vid_de,
    output logic                frame_start,
    output logic                underflow
);
    import celery_pkg::*;

    localparam int unsigned HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int unsigned VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic SYNC_ON = (SYNC_ACTIVE_HIGH != 0);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          raw_active;
    logic          raw_hsync;
    logic          raw_vsync;
    logic          raw_first;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .active      (raw_active),
        .hsync       (raw_hsync),
        .vsync       (raw_vsync),
        .first_pixel (raw_first)
    );

    pix_tag_t tag_now;
    logic     in_fb;

    always_comb begin
        in_fb          = raw_active && (32'(h_cnt) < FB_WIDTH) && (32'(v_cnt) < FB_HEIGHT);
        tag_now.de     = raw_active && enable;
        tag_now.hsync  = raw_hsync;
        tag_now.vsync  = raw_vsync;
        tag_now.first  = raw_first;
        tag_now.issued = in_fb && enable;
    end

    // pipe[0] is the fetch stage (same cycle as fb_read_en); pipe[READ_LATENCY]
    // is the stage whose read data is on fb_read_data right now.
    pix_tag_t pipe [READ_LATENCY+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_read_en <= 1'b0;
            fb_read_x  <= '0;
            fb_read_y  <= '0;
            for (int unsigned i = 0; i <= READ_LATENCY; i++)
                pipe[i] <= '0;
        end else begin
            fb_read_en <= tag_now.issued;
            fb_read_x  <= XW'(h_cnt);
            fb_read_y  <= YW'(v_cnt);
            pipe[0]    <= tag_now;
            for (int unsigned i = 1; i <= READ_LATENCY; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    pix_tag_t cap;
    rgb565_t  pix;
    logic     uf_next;

    // Valid data without a matching issued read is simply ignored.
    always_comb begin
        cap     = pipe[READ_LATENCY];
        pix     = border_color;
        uf_next = 1'b0;
        if (cap.issued) begin
            if (fb_read_valid)
                pix = fb_read_data;
            else
                uf_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vid_rgb     <= '0;
            vid_de      <= 1'b0;
            vid_hsync   <= ~SYNC_ON;
            vid_vsync   <= ~SYNC_ON;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            vid_de      <= cap.de;
            vid_rgb     <= cap.de ? rgb565_to_888(pix) : '0;
            vid_hsync   <= cap.hsync ? SYNC_ON : ~SYNC_ON;
            vid_vsync   <= cap.vsync ? SYNC_ON : ~SYNC_ON;
            frame_start <= cap.first;
            underflow   <= uf_next;
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout. Four instances share one clock:
//   u_main : small timing 8/2/2/2 x 4/1/1/1, FB 8x4, latency 1, (2,1) never returns data
//   u_brd  : same timing, FB_WIDTH 4, border 0x001F
//   u_l3   : same timing, READ_LATENCY 3, (2,1) never returns data
//   u_dflt : default horizontal timing, short vertical (4/1/1/1), constant white FB
module tb_fb_scanout;
    import celery_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst = 1'b1;
    logic m_rp = 1'b0;
    logic m_enable = 1'b1;
    logic m_armed = 1'b0;
    logic run = 1'b0;
    logic rst_m;
    assign rst_m = rst | m_rp;

    typedef struct {
        logic [23:0] rgb;
        logic        uf;
        logic        fs;
        int          x;
        int          y;
    } exp_t;

    exp_t q_m[$];
    exp_t q_b[$];
    exp_t q_t[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Framebuffer contents: row 0 is a hand-picked colour set, other rows a position code
    function automatic logic [15:0] mem_pix(input int x, input int y);
        if (y == 0) begin
            case (x)
                0: return 16'hF800;
                1: return 16'h07E0;
                2: return 16'h001F;
                3: return 16'hFFFF;
                4: return 16'h0000;
                5: return 16'h8410;
                6: return 16'h0841;
                default: return 16'hAAAA;
            endcase
        end
        return {4'(y), 4'(x), 8'h5A};
    endfunction

    function automatic logic [23:0] expand(input logic [15:0] c);
        int r5, g6, b5;
        r5 = int'(c[15:11]);
        g6 = int'(c[10:5]);
        b5 = int'(c[4:0]);
        return {8'(r5 * 8 + r5 / 4), 8'(g6 * 4 + g6 / 16), 8'(b5 * 8 + b5 / 4)};
    endfunction

    function automatic logic [23:0] exp_pix(input int x, input int y);
        if (y == 0) begin
            case (x)
                0: return 24'hFF0000;
                1: return 24'h00FF00;
                2: return 24'h0000FF;
                3: return 24'hFFFFFF;
                4: return 24'h000000;
                5: return 24'h848284;
                6: return 24'h080808;
                default: return 24'hAD5552;
            endcase
        end
        return expand(mem_pix(x, y));
    endfunction

    // ---------------- u_main ----------------
    logic [2:0]  m_x;
    logic [1:0]  m_y;
    logic        m_en, m_hs, m_vs, m_de, m_fs, m_uf;
    logic [23:0] m_rgb;
    logic        m_vld = 1'b0;
    logic [15:0] m_dat = '0;

    fb_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_ACTIVE_HIGH(0), .FB_WIDTH(8), .FB_HEIGHT(4), .READ_LATENCY(1)
    ) u_main (
        .clk(clk), .rst(rst_m), .enable(m_enable), .border_color(16'hF81F),
        .fb_read_x(m_x), .fb_read_y(m_y), .fb_read_en(m_en),
        .fb_read_data(m_dat), .fb_read_valid(m_vld),
        .vid_rgb(m_rgb), .vid_hsync(m_hs), .vid_vsync(m_vs), .vid_de(m_de),
        .frame_start(m_fs), .underflow(m_uf)
    );

    always @(posedge clk) begin
        m_vld <= m_en && !(m_x == 3'd2 && m_y == 2'd1);
        m_dat <= mem_pix(int'(m_x), int'(m_y));
    end

    // ---------------- u_brd ----------------
    logic [1:0]  b_x;
    logic [1:0]  b_y;
    logic        b_en, b_hs, b_vs, b_de, b_fs, b_uf;
    logic [23:0] b_rgb;
    logic        b_vld = 1'b0;
    logic [15:0] b_dat = '0;

    fb_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_ACTIVE_HIGH(0), .FB_WIDTH(4), .FB_HEIGHT(4), .READ_LATENCY(1)
    ) u_brd (
        .clk(clk), .rst(rst), .enable(1'b1), .border_color(16'h001F),
        .fb_read_x(b_x), .fb_read_y(b_y), .fb_read_en(b_en),
        .fb_read_data(b_dat), .fb_read_valid(b_vld),
        .vid_rgb(b_rgb), .vid_hsync(b_hs), .vid_vsync(b_vs), .vid_de(b_de),
        .frame_start(b_fs), .underflow(b_uf)
    );

    always @(posedge clk) begin
        b_vld <= b_en;
        b_dat <= mem_pix(int'(b_x), int'(b_y));
    end

    // ---------------- u_l3 ----------------
    logic [2:0]  t_x;
    logic [1:0]  t_y;
    logic        t_en, t_hs, t_vs, t_de, t_fs, t_uf;
    logic [23:0] t_rgb;
    logic [2:0]  t_vp = '0;
    logic [15:0] t_dp [3] = '{default: '0};

    fb_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_ACTIVE_HIGH(0), .FB_WIDTH(8), .FB_HEIGHT(4), .READ_LATENCY(3)
    ) u_l3 (
        .clk(clk), .rst(rst), .enable(1'b1), .border_color(16'hF81F),
        .fb_read_x(t_x), .fb_read_y(t_y), .fb_read_en(t_en),
        .fb_read_data(t_dp[2]), .fb_read_valid(t_vp[2]),
        .vid_rgb(t_rgb), .vid_hsync(t_hs), .vid_vsync(t_vs), .vid_de(t_de),
        .frame_start(t_fs), .underflow(t_uf)
    );

    always @(posedge clk) begin
        t_vp    <= {t_vp[1:0], t_en && !(t_x == 3'd2 && t_y == 2'd1)};
        t_dp[0] <= mem_pix(int'(t_x), int'(t_y));
        t_dp[1] <= t_dp[0];
        t_dp[2] <= t_dp[1];
    end

    // ---------------- u_dflt ----------------
    logic [9:0]  d_x;
    logic [8:0]  d_y;
    logic        d_en, d_hs, d_vs, d_de, d_fs, d_uf;
    logic [23:0] d_rgb;
    logic        d_vld = 1'b0;

    fb_scanout #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_dflt (
        .clk(clk), .rst(rst), .enable(1'b1), .border_color(16'h0000),
        .fb_read_x(d_x), .fb_read_y(d_y), .fb_read_en(d_en),
        .fb_read_data(16'hFFFF), .fb_read_valid(d_vld),
        .vid_rgb(d_rgb), .vid_hsync(d_hs), .vid_vsync(d_vs), .vid_de(d_de),
        .frame_start(d_fs), .underflow(d_uf)
    );

    always @(posedge clk) d_vld <= d_en;

    // ---------------- monitors ----------------
    int rd0_m = -1, de0_m = -1, rd0_t = -1, de0_t = -1;
    int b_ufc = 0;

    always @(negedge clk) begin
        exp_t e;
        if (m_armed) begin
            if (m_en && rd0_m < 0) rd0_m = cyc;
            if (m_de && de0_m < 0) de0_m = cyc;
            if (m_de) begin
                checks++;
                if (q_m.size() == 0) begin
                    errors++;
                    $display("FAIL m_extra: got de with rgb=%h, expected no pixel", m_rgb);
                end else begin
                    e = q_m.pop_front();
                    if (m_rgb !== e.rgb || m_uf !== e.uf || m_fs !== e.fs) begin
                        errors++;
                        $display("FAIL m_pix(%0d,%0d): got rgb=%h uf=%b fs=%b expected rgb=%h uf=%b fs=%b",
                                 e.x, e.y, m_rgb, m_uf, m_fs, e.rgb, e.uf, e.fs);
                    end
                end
            end else if (m_uf || m_fs || m_rgb != 24'h0) begin
                checks++;
                errors++;
                $display("FAIL m_idle: got uf=%b fs=%b rgb=%h with de=0, expected 0/0/0", m_uf, m_fs, m_rgb);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (run) begin
            if (b_uf) b_ufc++;
            if (b_de && q_b.size() != 0) begin
                e = q_b.pop_front();
                checks++;
                if (b_rgb !== e.rgb || b_uf !== e.uf || b_fs !== e.fs) begin
                    errors++;
                    $display("FAIL b_pix(%0d,%0d): got rgb=%h uf=%b fs=%b expected rgb=%h uf=%b fs=%b",
                             e.x, e.y, b_rgb, b_uf, b_fs, e.rgb, e.uf, e.fs);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (run) begin
            if (t_en && rd0_t < 0) rd0_t = cyc;
            if (t_de && de0_t < 0) de0_t = cyc;
            if (t_de && q_t.size() != 0) begin
                e = q_t.pop_front();
                checks++;
                if (t_rgb !== e.rgb || t_uf !== e.uf || t_fs !== e.fs) begin
                    errors++;
                    $display("FAIL t_pix(%0d,%0d): got rgb=%h uf=%b fs=%b expected rgb=%h uf=%b fs=%b",
                             e.x, e.y, t_rgb, t_uf, t_fs, e.rgb, e.uf, e.fs);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        // main: frame0 full, frame1 line 2 disabled, frame2 cut by reset after (1,1), frame3 full
        for (int f = 0; f < 4; f++)
            for (int y = 0; y < 4; y++)
                for (int x = 0; x < 8; x++) begin
                    logic uf;
                    if (f == 1 && y == 2) continue;
                    if (f == 2 && (y > 1 || (y == 1 && x > 1))) continue;
                    uf = (x == 2 && y == 1);
                    q_m.push_back('{uf ? 24'hFF00FF : exp_pix(x, y), uf, (x == 0 && y == 0), x, y});
                end
        for (int f = 0; f < 3; f++)
            for (int y = 0; y < 4; y++)
                for (int x = 0; x < 8; x++) begin
                    logic uf;
                    uf = (x == 2 && y == 1);
                    q_b.push_back('{(x >= 4) ? 24'h0000FF : exp_pix(x, y), 1'b0, (x == 0 && y == 0), x, y});
                    q_t.push_back('{uf ? 24'hFF00FF : exp_pix(x, y), uf, (x == 0 && y == 0), x, y});
                end

        repeat (3) @(posedge clk);
        #2;
        chk("rst_hsync", 32'(m_hs), 32'd1);
        chk("rst_vsync", 32'(m_vs), 32'd1);
        chk("rst_de", 32'(m_de), 32'd0);
        chk("rst_rgb", 32'(m_rgb), 32'd0);
        chk("rst_read_en", 32'(m_en), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        m_armed = 1'b1;
        run = 1'b1;

        fork
            begin : main_seq
                int rds, hsl;
                @(posedge clk);
                #2;
                chk("first_read_en", 32'(m_en), 32'd1);
                chk("first_read_x", 32'(m_x), 32'd0);
                chk("first_read_y", 32'(m_y), 32'd0);
                repeat (125) @(posedge clk);
                #1 m_enable = 1'b0;
                rds = 0;
                hsl = 0;
                for (int i = 0; i < 14; i++) begin
                    @(posedge clk);
                    #2;
                    if (m_en) rds++;
                    if (!m_hs) hsl++;
                end
                m_enable = 1'b1;
                chk("dis_reads", 32'(rds), 32'd0);
                chk("dis_hsync_low", 32'(hsl), 32'd2);
                repeat (74) @(posedge clk);
                #1 m_rp = 1'b1;
                @(posedge clk);
                #2;
                chk("mid_rst_de", 32'(m_de), 32'd0);
                chk("mid_rst_rgb", 32'(m_rgb), 32'd0);
                chk("mid_rst_read_en", 32'(m_en), 32'd0);
                chk("mid_rst_hsync", 32'(m_hs), 32'd1);
                chk("mid_rst_vsync", 32'(m_vs), 32'd1);
                chk("mid_rst_fs", 32'(m_fs), 32'd0);
                chk("mid_rst_uf", 32'(m_uf), 32'd0);
                m_rp = 1'b0;
                @(posedge clk);
                #2;
                chk("restart_read_en", 32'(m_en), 32'd1);
                chk("restart_read_x", 32'(m_x), 32'd0);
                chk("restart_read_y", 32'(m_y), 32'd0);
                repeat (85) @(posedge clk);
                m_armed = 1'b0;
            end
            begin : brd_reads
                int rds;
                rds = 0;
                @(posedge clk);
                for (int i = 0; i < 98; i++) begin
                    @(negedge clk);
                    if (b_en) rds++;
                end
                chk("brd_reads_per_frame", 32'(rds), 32'd16);
            end
            begin : dflt_timing
                int hs, hs_line, vs, de, fs, fsde, bad;
                hs = 0; hs_line = 0; vs = 0; de = 0; fs = 0; fsde = 0; bad = 0;
                repeat (10) @(posedge clk);
                for (int i = 0; i < 5600; i++) begin
                    @(negedge clk);
                    if (!d_hs) hs++;
                    if (!d_hs && i < 800) hs_line++;
                    if (!d_vs) vs++;
                    if (d_de) de++;
                    if (d_fs) begin
                        fs++;
                        if (d_de) fsde++;
                    end
                    if (d_de && d_rgb !== 24'hFFFFFF) bad++;
                end
                chk("dflt_hsync_low_line", 32'(hs_line), 32'd96);
                chk("dflt_hsync_low_frame", 32'(hs), 32'd672);
                chk("dflt_vsync_low", 32'(vs), 32'd800);
                chk("dflt_de_count", 32'(de), 32'd2560);
                chk("dflt_frame_start", 32'(fs), 32'd1);
                chk("dflt_fs_with_de", 32'(fsde), 32'd1);
                chk("dflt_rgb_bad", 32'(bad), 32'd0);
            end
        join

        chk("lat_main", 32'(de0_m - rd0_m), 32'd2);
        chk("lat_l3", 32'(de0_t - rd0_t), 32'd4);
        chk("brd_underflow", 32'(b_ufc), 32'd0);
        chk("q_main_left", 32'(q_m.size()), 32'd0);
        chk("q_brd_left", 32'(q_b.size()), 32'd0);
        chk("q_l3_left", 32'(q_t.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
